// File: rtl/sd_defs.sv
// sd_defs: shared sector geometry and packer state encoding for the SD storage path
package sd_defs;
  localparam int WORD_BITS   = 32;
  localparam int ADDR_W      = 7;
  localparam int SEC_ADDR_W  = 32;
  localparam int WORDS       = 1 << ADDR_W;
  localparam int SECTOR_BITS = WORD_BITS << ADDR_W;
  localparam int BIT_W       = $clog2(WORD_BITS);
  typedef enum logic [1:0] {IDLE, FILL, FLUSH} sd_state_e;
endpackage

// File: rtl/sd_word_insert.sv
// sd_word_insert: merge one word into a sector image, word bit 31-i landing at sector bit {addr,i}
module sd_word_insert
  import sd_defs::*;
(
  input  logic [SECTOR_BITS-1:0] sec_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [WORD_BITS-1:0]   word_i,
  output logic [SECTOR_BITS-1:0] sec_o
);
  // bit-reversed placement mirrors the read divider so data round-trips unchanged
  always_comb begin
    sec_o = sec_i;
    for (int i = 0; i < WORD_BITS; i++) sec_o[{addr_i, i[BIT_W-1:0]}] = word_i[WORD_BITS-1-i];
  end
endmodule

// File: rtl/sd_write_pack.sv
// sd_write_pack: packs 32-bit words into a 512-byte sector and hands it to the SD writer; SD_WRITE_AUTOFLUSH_EN starts a flush when the 128th distinct word arrives
module sd_write_pack
  import sd_defs::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WORD_BITS-1:0]   wr_data,
  input  logic                   load_en,
  input  logic [SECTOR_BITS-1:0] load_data,
  input  logic                   flush,
  input  logic [SEC_ADDR_W-1:0]  sec_addr_in,
  output logic                   busy,
  output logic [ADDR_W:0]        words_cnt,
  output logic                   sd_wr_req,
  output logic [SEC_ADDR_W-1:0]  sd_wr_addr,
  output logic [SECTOR_BITS-1:0] sd_wr_data,
  input  logic                   sd_wr_ack,
  output logic                   done
);
`ifdef SD_WRITE_AUTOFLUSH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(WORDS - 1);
  sd_state_e              state_q, state_d;
  logic [SECTOR_BITS-1:0] sec_q, sec_d, sec_ld, sec_ins;
  logic [WORDS-1:0]       mask_q, mask_d;
  logic [ADDR_W:0]        cnt_q, cnt_d;
  logic [SEC_ADDR_W-1:0]  addr_q, addr_d;
  logic                   done_q, done_d, acc, fin, new_word, go;
  sd_word_insert u_ins (.sec_i(sec_ld), .addr_i(wr_addr), .word_i(wr_data), .sec_o(sec_ins));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state and datapath updates; load is applied under the write, both before a flush freezes the buffer
  always_comb begin
    acc      = state_q != FLUSH;
    fin      = state_q == FLUSH && sd_wr_ack;
    new_word = acc && wr_en && !mask_q[wr_addr];
    go       = acc && (flush || (AUTO && new_word && cnt_q == CNT_LAST));
    sec_ld   = load_en ? load_data : sec_q;
    sec_d    = acc ? (wr_en ? sec_ins : sec_ld) : sec_q;
    mask_d   = fin ? '0 : mask_q | ({{(WORDS-1){1'b0}}, new_word} << wr_addr);
    cnt_d    = fin ? '0 : cnt_q + {{ADDR_W{1'b0}}, new_word};
    addr_d   = go ? sec_addr_in : addr_q;
    done_d   = fin;
    state_d  = !acc ? (sd_wr_ack ? IDLE : FLUSH) : go ? FLUSH : (cnt_d != '0 ? FILL : IDLE);
  end
  // buffer, written-mask, counter, address and done pulse registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sec_q  <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  assign busy       = state_q == FLUSH;
  assign sd_wr_req  = busy;
  assign sd_wr_addr = addr_q;
  assign sd_wr_data = sec_q;
  assign words_cnt  = cnt_q;
  assign done       = done_q;
endmodule

// File: tb/tb_sd_write_pack.sv
// tb_sd_write_pack: directed self-checking bench for the sector write packer
module tb_sd_write_pack;
  import sd_defs::*;
  logic                   clk = 0, rst = 1;
  logic                   wr_en = 0, load_en = 0, flush = 0, sd_wr_ack = 0;
  logic [ADDR_W-1:0]      wr_addr = '0;
  logic [WORD_BITS-1:0]   wr_data = '0;
  logic [SECTOR_BITS-1:0] load_data = '0;
  logic [SEC_ADDR_W-1:0]  sec_addr_in = '0;
  logic                   busy, sd_wr_req, done;
  logic [ADDR_W:0]        words_cnt;
  logic [SEC_ADDR_W-1:0]  sd_wr_addr;
  logic [SECTOR_BITS-1:0] sd_wr_data;
  logic [SECTOR_BITS-1:0] mbuf = '0, exp_v;
  int tests = 0, fails = 0;
  sd_write_pack dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_en(load_en), .load_data(load_data), .flush(flush), .sec_addr_in(sec_addr_in),
    .busy(busy), .words_cnt(words_cnt), .sd_wr_req(sd_wr_req), .sd_wr_addr(sd_wr_addr),
    .sd_wr_data(sd_wr_data), .sd_wr_ack(sd_wr_ack), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [WORD_BITS-1:0] rd_word(input logic [SECTOR_BITS-1:0] s, input int a);
    logic [WORD_BITS-1:0] w;
    for (int i = 0; i < WORD_BITS; i++) w[WORD_BITS-1-i] = s[a*WORD_BITS+i];
    return w;
  endfunction
  function automatic logic [SECTOR_BITS-1:0] put_word(input logic [SECTOR_BITS-1:0] s, input int a, input logic [WORD_BITS-1:0] w);
    for (int i = 0; i < WORD_BITS; i++) s[a*WORD_BITS+i] = w[WORD_BITS-1-i];
    return s;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    wr_en = 0; load_en = 0; flush = 0; sd_wr_ack = 0;
  endtask
  task automatic wr(input int a, input logic [WORD_BITS-1:0] d);
    wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    idle_in();
    mbuf = put_word(mbuf, a, d);
  endtask
  task automatic do_flush(input logic [SEC_ADDR_W-1:0] a);
    flush = 1; sec_addr_in = a;
    tick();
    idle_in();
  endtask
  task automatic do_ack();
    sd_wr_ack = 1;
    tick();
    idle_in();
  endtask
  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    tests++; if (sd_wr_req !== 0 || busy !== 0 || done !== 0 || words_cnt !== 0 || sd_wr_addr !== 0) begin fails++; $display("FAIL reset_init req=%b busy=%b done=%b cnt=%0d addr=%h want all 0", sd_wr_req, busy, done, words_cnt, sd_wr_addr); end
    wr(1, 32'hFFFF_FFFF);
    do_flush(32'h99);
    tests++; if (sd_wr_req !== 1) begin fails++; $display("FAIL reset_preflush req=%b want 1", sd_wr_req); end
    #2 rst = 1;
    #1;
    tests++; if (sd_wr_req !== 0 || busy !== 0 || done !== 0 || words_cnt !== 0 || sd_wr_addr !== 0) begin fails++; $display("FAIL reset_async req=%b busy=%b done=%b cnt=%0d addr=%h want all 0", sd_wr_req, busy, done, words_cnt, sd_wr_addr); end
    tick();
    rst = 0;
    mbuf = '0;
    do_flush(32'h0);
    tests++; if (sd_wr_req !== 1 || sd_wr_data !== '0) begin fails++; $display("FAIL reset_buffer req=%b nonzero_bits=%0d want req=1 zero buffer", sd_wr_req, $countones(sd_wr_data)); end
    do_ack();
  endtask
  task automatic test_basic();
    wr(0, 32'h8000_0001);
    wr(127, 32'h0000_0001);
    tests++; if (words_cnt !== 2) begin fails++; $display("FAIL basic_cnt got %0d want 2", words_cnt); end
    do_flush(32'h10);
    exp_v = '0; exp_v[0] = 1; exp_v[31] = 1; exp_v[4095] = 1;
    tests++; if (sd_wr_req !== 1 || busy !== 1 || sd_wr_addr !== 32'h10) begin fails++; $display("FAIL basic_req req=%b busy=%b addr=%h want 1 1 10", sd_wr_req, busy, sd_wr_addr); end
    tests++; if (sd_wr_data !== exp_v) begin fails++; $display("FAIL basic_bits ones=%0d b0=%b b31=%b b4095=%b want 3 ones at 0,31,4095", $countones(sd_wr_data), sd_wr_data[0], sd_wr_data[31], sd_wr_data[4095]); end
    tests++; if (rd_word(sd_wr_data, 0) !== 32'h8000_0001 || rd_word(sd_wr_data, 127) !== 32'h1) begin fails++; $display("FAIL basic_roundtrip w0=%h w127=%h want 80000001 00000001", rd_word(sd_wr_data, 0), rd_word(sd_wr_data, 127)); end
    do_ack();
    tests++; if (sd_wr_req !== 0 || done !== 1 || words_cnt !== 0) begin fails++; $display("FAIL basic_ack req=%b done=%b cnt=%0d want 0 1 0", sd_wr_req, done, words_cnt); end
    tick();
    tests++; if (done !== 0) begin fails++; $display("FAIL basic_done_pulse done=%b want 0", done); end
  endtask
  task automatic test_rewrite();
    wr(5, 32'hAAAA_5555);
    wr(5, 32'h1234_5678);
    tests++; if (words_cnt !== 1) begin fails++; $display("FAIL rewrite_cnt got %0d want 1", words_cnt); end
    do_flush(32'h20);
    tests++; if (rd_word(sd_wr_data, 5) !== 32'h1234_5678 || sd_wr_data !== mbuf) begin fails++; $display("FAIL rewrite_word got %h want 12345678", rd_word(sd_wr_data, 5)); end
    do_ack();
  endtask
  task automatic test_load_write();
    load_en = 1; load_data = '1; wr_en = 1; wr_addr = 3; wr_data = 32'h0;
    tick();
    idle_in();
    mbuf = '1; mbuf[127:96] = '0;
    tests++; if (words_cnt !== 1) begin fails++; $display("FAIL load_cnt got %0d want 1", words_cnt); end
    do_flush(32'h30);
    tests++; if (sd_wr_data !== mbuf) begin fails++; $display("FAIL load_data ones=%0d w3=%h want 4064 ones w3=00000000", $countones(sd_wr_data), rd_word(sd_wr_data, 3)); end
    do_ack();
  endtask
  task automatic test_hold();
    wr(9, 32'h0F0F_0000);
    do_flush(32'h55);
    for (int c = 0; c < 3; c++) begin
      wr_en = 1; wr_addr = 10; wr_data = 32'hDEAD_BEEF; flush = c[0]; load_en = 1; load_data = '0; sec_addr_in = 32'h66;
      tick();
      idle_in();
      tests++; if (sd_wr_req !== 1 || sd_wr_addr !== 32'h55 || sd_wr_data !== mbuf || words_cnt !== 1 || done !== 0) begin fails++; $display("FAIL hold_c%0d req=%b addr=%h data_ok=%b cnt=%0d done=%b want 1 55 1 1 0", c, sd_wr_req, sd_wr_addr, sd_wr_data === mbuf, words_cnt, done); end
    end
    do_ack();
    tests++; if (done !== 1 || sd_wr_req !== 0) begin fails++; $display("FAIL hold_ack done=%b req=%b want 1 0", done, sd_wr_req); end
    sd_wr_ack = 1;
    tick();
    idle_in();
    tests++; if (done !== 0 || sd_wr_req !== 0) begin fails++; $display("FAIL hold_stray_ack done=%b req=%b want 0 0", done, sd_wr_req); end
  endtask
  task automatic test_full();
    sec_addr_in = 32'h77;
    for (int a = 0; a < WORDS; a++) wr(a, WORD_BITS'(a + 32'h100));
`ifdef SD_WRITE_AUTOFLUSH_EN
    tests++; if (sd_wr_req !== 1 || sd_wr_addr !== 32'h77 || sd_wr_data !== mbuf) begin fails++; $display("FAIL full_auto req=%b addr=%h data_ok=%b want 1 77 1", sd_wr_req, sd_wr_addr, sd_wr_data === mbuf); end
    do_ack();
`else
    tests++; if (words_cnt !== 128 || sd_wr_req !== 0) begin fails++; $display("FAIL full_cnt cnt=%0d req=%b want 128 0", words_cnt, sd_wr_req); end
    wr(0, 32'h5);
    tests++; if (words_cnt !== 128 || sd_wr_req !== 0) begin fails++; $display("FAIL full_sat cnt=%0d req=%b want 128 0", words_cnt, sd_wr_req); end
    do_flush(32'h78);
    tests++; if (sd_wr_req !== 1 || sd_wr_addr !== 32'h78 || sd_wr_data !== mbuf) begin fails++; $display("FAIL full_flush req=%b addr=%h data_ok=%b want 1 78 1", sd_wr_req, sd_wr_addr, sd_wr_data === mbuf); end
    do_ack();
`endif
    tests++; if (words_cnt !== 0 || done !== 1) begin fails++; $display("FAIL full_done cnt=%0d done=%b want 0 1", words_cnt, done); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_rewrite();
    test_load_write();
    test_hold();
    test_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_write_pack.md
Name: sd_write_pack

Overview:
Write-side sector packer for the SD storage path. It assembles 32-bit CPU/cache words into a 4096-bit (512-byte) sector buffer. It then hands the whole sector to the SD write controller through a req/ack handshake. Its word-to-bit mapping is the exact inverse of the sector read divider: word `a` bit 31-i is stored at buffer bit `{a, i}`. Data therefore round-trips unchanged.

Parameters:
- SECTOR_BITS, 4096, sector buffer width; must equal WORD_BITS << ADDR_W.
- WORD_BITS, 32, width of one word.
- ADDR_W, 7, word index width (128 words per sector).
- SEC_ADDR_W, 32, SD sector address width.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- wr_en, input, 1, write one word into the buffer this cycle.
- wr_addr, input, ADDR_W, word index within the sector.
- wr_data, input, WORD_BITS, word to store.
- load_en, input, 1, preload the whole buffer (read-modify-write from a sector just read).
- load_data, input, SECTOR_BITS, preload image, in the same bit order as the read path.
- flush, input, 1, request write-out of the buffer.
- sec_addr_in, input, SEC_ADDR_W, target sector, sampled when a flush is accepted.
- busy, output, 1, high in FLUSH; word writes and loads are ignored while high.
- words_cnt, output, ADDR_W+1, distinct words written since the last completed flush (0..128).
- sd_wr_req, output, 1, sector valid to the SD write controller.
- sd_wr_addr, output, SEC_ADDR_W, latched sector address.
- sd_wr_data, output, SECTOR_BITS, buffer contents, held stable while sd_wr_req is high.
- sd_wr_ack, input, 1, controller accepted the sector.
- done, output, 1, one-cycle pulse when the flush completes.

Behaviour:
- Reset (async, rst=1):
  - Buffer, written-mask (128 b), words_cnt, sd_wr_addr all 0.
  - sd_wr_req=0, busy=0, done=0, state IDLE.
  - Reset asserted mid-flush aborts it; sd_wr_req drops immediately.
- States:
  - IDLE: words_cnt==0.
  - FILL: words_cnt>0.
  - FLUSH: sd_wr_req=1 and busy=1.
  - IDLE→FILL on the first accepted wr_en.
  - IDLE/FILL→FLUSH on flush.
  - FLUSH→IDLE on sd_wr_ack.
- Word write (IDLE/FILL only):
  - buf[{wr_addr,i}] <= wr_data[31-i] for i=0..31.
  - Sets mask[wr_addr]. words_cnt increments only if that mask bit was clear, so a rewrite of the same index overwrites the data without counting.
- Load (IDLE/FILL only):
  - buf <= load_data. Mask and words_cnt are unchanged.
  - load_en and wr_en in the same cycle: the load applies first, and the addressed word takes wr_data.
- Flush:
  - Accepted in IDLE or FILL, including with words_cnt=0 (writes the buffer as is).
  - sec_addr_in is latched into sd_wr_addr. sd_wr_req rises the next cycle (latency 1).
  - flush together with wr_en/load_en: the write or load is applied before the buffer freezes.
  - flush while in FLUSH is ignored.
- Handshake:
  - sd_wr_req, sd_wr_addr and sd_wr_data are held stable until sd_wr_ack is sampled high while sd_wr_req=1.
  - On that ack, next cycle: sd_wr_req=0, done=1 for one cycle, mask and words_cnt cleared, state IDLE. Buffer contents are retained.
  - sd_wr_ack while sd_wr_req=0 is ignored.
- In FLUSH, wr_en and load_en are dropped silently. Upstream must honour busy.
- sd_wr_data is driven continuously from the buffer; it is only guaranteed valid while sd_wr_req=1.

Optional Feature:
- Macro: SD_WRITE_AUTOFLUSH_EN.
- Defined: an accepted write that raises words_cnt to 128 also starts a flush in the same cycle, using sec_addr_in sampled in that cycle. sd_wr_req rises the next cycle, exactly as for an explicit flush.
- Undefined: words_cnt saturates at 128, the state stays FILL, and only an explicit flush starts a write-out.

Decomposition:
- Shared package/header `sd_defs`:
  - SECTOR_BITS, WORD_BITS, ADDR_W, SEC_ADDR_W.
  - State encodings IDLE/FILL/FLUSH.
  - Reused by the read divider and the SD controller.
- One natural sub-module, `sd_word_insert`: purely combinational. Takes buffer, addr and word, and returns the merged buffer using the inverse bit mapping. It is the mirror of the read divider.
- The FSM, mask, counter and handshake stay in sd_write_pack.

Test Plan:
1. Reset mid-FLUSH (sd_wr_req=1) → sd_wr_req, busy, done, words_cnt, sd_wr_addr all 0 asynchronously; buffer reads back all zeros on the next flush.
2. Write addr 0 = 0x80000001 and addr 127 = 0x00000001, then flush with sec_addr_in=0x10 → one cycle later sd_wr_req=1 and sd_wr_addr=0x10. sd_wr_data bits 0, 31 and 4095 are 1, all others 0. The read divider returns the same words. Ack → done pulse, words_cnt=0.
3. Write addr 5 = 0xAAAA5555, then addr 5 = 0x12345678 → words_cnt=1; the flushed word 5 reads 0x12345678.
4. load_en with all-ones plus wr_en addr 3 = 0 in the same cycle → the flushed sector is all ones except bits 96..127 = 0; words_cnt=1.
5. In FLUSH, withhold ack for 3 cycles while pulsing wr_en and flush → sd_wr_req stays high, data and address unchanged, words_cnt unchanged. Ack → single done pulse.
6. 128 distinct writes: with SD_WRITE_AUTOFLUSH_EN, sd_wr_req=1 the cycle after the last write. Without it, words_cnt=128, sd_wr_req=0, and a further rewrite keeps words_cnt at 128.
